// File: rtl/barrido_display_if.sv
// rtl/barrido_display_if.sv - segment/anode scanner bus; brillo present only with BARRIDO_DIMMING_EN
interface barrido_display_if;
  logic [0:6] parte_0;
  logic [0:6] parte_1;
  logic [0:6] parte_2;
  logic [0:6] parte_3;
  logic       load;
  logic       enable;
  logic [3:0] blink_mask;
`ifdef BARRIDO_DIMMING_EN
  logic [2:0] brillo;
`endif
  logic [0:6] segmentos;
  logic [3:0] anodos;
  logic [1:0] digit_idx;
  logic       frame_tick;

  modport master (
`ifdef BARRIDO_DIMMING_EN
    output brillo,
`endif
    output parte_0, parte_1, parte_2, parte_3, load, enable, blink_mask,
    input  segmentos, anodos, digit_idx, frame_tick
  );

  modport slave (
`ifdef BARRIDO_DIMMING_EN
    input  brillo,
`endif
    input  parte_0, parte_1, parte_2, parte_3, load, enable, blink_mask,
    output segmentos, anodos, digit_idx, frame_tick
  );
endinterface

// File: rtl/barrido_display.sv
// rtl/barrido_display.sv - 4-digit 7-segment scanner with double buffer, dead time and blink
// Optional PWM dimming of the anodes is enabled with BARRIDO_DIMMING_EN.
module barrido_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic               clk,
  input  logic               reset,
  barrido_display_if.slave   bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM = DIV_W'(DEAD_CYCLES);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);
  localparam logic [0:6]       SEG_OFF  = 7'b1111111;

  logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
  logic [1:0]       digit_idx_q,   digit_idx_d;
  logic [FR_W-1:0]  frame_cnt_q,   frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [0:6]       pend_q [4];
  logic [0:6]       pend_d [4];
  logic [0:6]       act_q  [4];
  logic [0:6]       act_d  [4];
  logic [3:0]       anodos_q,      anodos_d;
  logic [0:6]       segmentos_q,   segmentos_d;
  logic             frame_tick_q,  frame_tick_d;
  logic [0:6]       parte_in [4];
  logic             slot_wrap, frame_wrap, lit, anode_on;
`ifdef BARRIDO_DIMMING_EN
  logic [2:0]       pwm_cnt_q,     pwm_cnt_d;
`endif

  assign parte_in[0] = bus.parte_0;
  assign parte_in[1] = bus.parte_1;
  assign parte_in[2] = bus.parte_2;
  assign parte_in[3] = bus.parte_3;

  always_comb begin
    slot_wrap  = (div_cnt_q == DIV_LAST);
    frame_wrap = slot_wrap && (digit_idx_q == 2'd3);

    div_cnt_d   = slot_wrap ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Active copies from pend_d, so a load on the wrap edge bypasses straight through.
    for (int i = 0; i < 4; i++) begin
      pend_d[i] = bus.load ? parte_in[i] : pend_q[i];
      act_d[i]  = frame_wrap ? pend_d[i] : act_q[i];
    end

    lit = bus.enable && (div_cnt_q >= DEAD_LIM);
`ifdef BARRIDO_DIMMING_EN
    pwm_cnt_d = pwm_cnt_q + 3'd1;
    anode_on  = lit && (pwm_cnt_q <= bus.brillo);
`else
    anode_on  = lit;
`endif
    anodos_d = anode_on ? ~(4'b0001 << digit_idx_q) : 4'b1111;

    // Blink blanks the segments only; the anode keeps its normal timing.
    if (lit && !(blink_phase_q && bus.blink_mask[digit_idx_q]))
      segmentos_d = act_q[digit_idx_q];
    else
      segmentos_d = SEG_OFF;

    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= SEG_OFF;
        act_q[i]  <= SEG_OFF;
      end
      anodos_q      <= 4'b1111;
      segmentos_q   <= SEG_OFF;
      frame_tick_q  <= 1'b0;
`ifdef BARRIDO_DIMMING_EN
      pwm_cnt_q     <= '0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      for (int i = 0; i < 4; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
      anodos_q      <= anodos_d;
      segmentos_q   <= segmentos_d;
      frame_tick_q  <= frame_tick_d;
`ifdef BARRIDO_DIMMING_EN
      pwm_cnt_q     <= pwm_cnt_d;
`endif
    end
  end

  assign bus.anodos     = anodos_q;
  assign bus.segmentos  = segmentos_q;
  assign bus.digit_idx  = digit_idx_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_barrido_display.sv
// tb/tb_barrido_display.sv - directed bench for barrido_display (8-cycle slots, 2-cycle dead time)
module tb_barrido_display;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t     = 0;

  logic [0:6] exp_act [4];
  logic [0:6] v1, v2, v3, v4, vz, vb;

  barrido_display_if bus ();

  barrido_display #(
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic set_parts(input logic [0:6] a, input logic [0:6] b,
                           input logic [0:6] c, input logic [0:6] d);
    bus.parte_0 = a;
    bus.parte_1 = b;
    bus.parte_2 = c;
    bus.parte_3 = d;
  endtask

  task automatic set_exp(input logic [0:6] a, input logic [0:6] b,
                         input logic [0:6] c, input logic [0:6] d);
    exp_act[0] = a;
    exp_act[1] = b;
    exp_act[2] = c;
    exp_act[3] = d;
  endtask

  // Step one edge and compare every output with the hand-derived scan position.
  task automatic step_chk();
    int         p, slot, dig, frame;
    logic       lit, blank;
    logic [3:0] exp_an;
    logic [0:6] exp_seg;
    @(posedge clk);
    #1;
    t++;
    p     = t - 1;
    slot  = p % 8;
    dig   = (p / 8) % 4;
    frame = p / 32;
    lit   = bus.enable && (slot >= 2);
    blank = bus.blink_mask[dig] && (((frame / 2) % 2) == 1);
    exp_an  = lit ? ~(4'b0001 << dig) : 4'b1111;
    exp_seg = (lit && !blank) ? exp_act[dig] : 7'b1111111;
    check_eq("anodos", 32'(bus.anodos), 32'(exp_an));
    check_eq("segmentos", 32'(bus.segmentos), 32'(exp_seg));
    check_eq("digit_idx", 32'(bus.digit_idx), 32'((t / 8) % 4));
    check_eq("frame_tick", 32'(bus.frame_tick), 32'((t % 32 == 0) && (t > 0)));
  endtask

  task automatic check_to(input int t_end);
    while (t < t_end) step_chk();
  endtask

  initial begin
    v1 = 7'b1001111;
    v2 = 7'b0010010;
    v3 = 7'b0000110;
    v4 = 7'b1001100;
    vz = 7'b0000000;
    vb = 7'b1111111;
    reset = 1'b1;
    bus.load = 1'b0;
    bus.enable = 1'b1;
    bus.blink_mask = 4'b0000;
`ifdef BARRIDO_DIMMING_EN
    bus.brillo = 3'd7;
`endif
    set_parts(vz, vz, vz, vz);
    set_exp(vb, vb, vb, vb);

    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_anodos", 32'(bus.anodos), 32'h0000000f);
    check_eq("rst_segmentos", 32'(bus.segmentos), 32'h0000007f);
    check_eq("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
    check_eq("rst_digit_idx", 32'(bus.digit_idx), 32'h0);

    reset = 1'b0;
    t = 0;
    check_to(3);
    set_parts(v1, v2, v3, v4);
    bus.load = 1'b1;
    check_to(4);
    bus.load = 1'b0;
    check_to(32);

    set_exp(v1, v2, v3, v4);
    check_to(72);
    set_parts(vz, vz, vz, vz);
    bus.load = 1'b1;
    check_to(73);
    bus.load = 1'b0;
    check_to(96);

    set_exp(vz, vz, vz, vz);
    check_to(127);
    set_parts(v1, v2, v3, v4);
    bus.load = 1'b1;
    check_to(128);
    bus.load = 1'b0;

    set_exp(v1, v2, v3, v4);
    bus.blink_mask = 4'b0001;
    check_to(320);
    bus.enable = 1'b0;
    check_to(420);
    bus.enable = 1'b1;
    check_to(436);

    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_anodos", 32'(bus.anodos), 32'h0000000f);
    check_eq("midrst_segmentos", 32'(bus.segmentos), 32'h0000007f);
    check_eq("midrst_digit_idx", 32'(bus.digit_idx), 32'h0);
    check_eq("midrst_frame_tick", 32'(bus.frame_tick), 32'h0);
    reset = 1'b0;
    t = 0;
    bus.blink_mask = 4'b0000;
    set_exp(vb, vb, vb, vb);
    check_to(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/barrido_display.md
Name: barrido_display

Overview:
- Time-multiplexed scanner for the 4-digit common-anode 7-segment display.
- Consumes the four decoded active-low segment buses produced by the message separator (parte_0..parte_3, bit order [0:6] = a..g). Drives the shared segment lines and the four anodes on the board.
- Adds double-buffering for tear-free updates, inter-digit dead time against ghosting, and per-digit blinking.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (1 kHz per digit at 50 MHz); must be greater than DEAD_CYCLES+1.
- DEAD_CYCLES, 16, cycles at the start of each slot with all anodes off.
- BLINK_FRAMES, 125, full frames per blink half-period.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- parte_0  input  [0:6]  rightmost digit segments, active-low
- parte_1  input  [0:6]  digit 1 segments
- parte_2  input  [0:6]  digit 2 segments
- parte_3  input  [0:6]  leftmost digit segments
- load  input  1  capture parte_0..3 into the pending buffer on this edge
- enable  input  1  0 = display dark
- blink_mask  input  [3:0]  bit i = 1 makes digit i blink
- segmentos  output  [0:6]  shared segment lines, active-low
- anodos  output  [3:0]  anodos[i] = 0 selects digit i
- digit_idx  output  [1:0]  digit currently being scanned
- frame_tick  output  1  one-cycle pulse at the start of each frame

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state is updated on the rising edge of clk.
- Reset values:
  - div_cnt = 0, digit_idx = 0, frame counter = 0, blink_phase = 0.
  - Pending and active buffers all 7'b1111111.
  - anodos = 4'b1111, segmentos = 7'b1111111, frame_tick = 0.
- Reset asserted mid-frame returns to these values on the next edge. No partial state survives.
- Slot counter:
  - div_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit_idx increments mod 4 (3 -> 0).
  - The edge where div_cnt = REFRESH_DIV-1 and digit_idx = 3 is the frame wrap.
- Buffers:
  - load = 1 writes parte_0..3 into the pending buffer.
  - At the frame wrap, active <= pending. If load = 1 on that same edge, active <= the parte inputs directly (bypass), and pending also captures them.
  - A load at any other time never changes the active buffer. The displayed frame therefore never tears.
- Blink:
  - frame_tick is registered and high for exactly the one cycle in which div_cnt = 0 and digit_idx = 0 following a frame wrap. The first frame after reset produces no tick.
  - The frame counter counts frame wraps 0..BLINK_FRAMES-1. On its wrap, blink_phase toggles.
- Output stage (registered, one-cycle latency from the state (digit_idx, div_cnt)):
  - enable = 0: anodos = 1111, segmentos = 1111111.
  - Otherwise, if div_cnt < DEAD_CYCLES: anodos = 1111, segmentos = 1111111.
  - Otherwise: anodos = one-cold at digit_idx, and segmentos = active[digit_idx].
  - In that last case, if blink_phase = 1 and blink_mask[digit_idx] = 1, segmentos = 1111111 and the anode stays asserted.
- Counters keep running while enable = 0, so frame_tick and blink continue.
- blink_mask and enable are sampled every cycle, not buffered.

Optional Feature:
- Macro: BARRIDO_DIMMING_EN.
- Defined:
  - Adds input brillo [2:0] and a free-running 3-bit pwm_cnt (reset 0, increments every cycle).
  - During the lit portion of a slot, the anode is asserted only when pwm_cnt <= brillo. Otherwise anodos = 1111.
  - brillo = 7 gives full brightness; brillo = 0 gives 1/8 duty.
  - segmentos is unaffected.
- Not defined: no brillo port, no pwm_cnt; full duty as above.

Test Plan:
(Bench parameters: REFRESH_DIV = 8, DEAD_CYCLES = 2, BLINK_FRAMES = 2; one frame = 32 cycles.)
- Reset held 5 cycles, then released -> anodos = 1111, segmentos = 1111111, frame_tick = 0, digit_idx = 0. The first lit output appears 3 cycles after release, with anodos = 1110 and segmentos = 1111111.
- Load '1','2','3','4' (parte_0 = 1001111, parte_1 = 0010010, parte_2 = 0000110, parte_3 = 1001100) in frame 0 -> starting with the frame after the next frame wrap:
  - Slot 0 shows anodos = 1110, segmentos = 1001111 for 6 cycles, after 2 blank cycles.
  - Slots 1..3 show 1101/0010010, 1011/0000110, 0111/1001100.
- Load new value 0000000 on all digits mid-frame (digit_idx = 1) -> outputs unchanged for the rest of that frame. The new value appears in the slot following frame_tick.
- load asserted exactly on the frame-wrap edge -> the new value is displayed in the immediately following frame (bypass).
- blink_mask = 0001 with a valid frame loaded -> digit 0 segmentos = 1111111 on alternating pairs of frames, visible on the other pairs. Digits 1..3 are always visible. anodos[0] still pulses low in every frame.
- enable = 0 for 100 cycles -> anodos = 1111 throughout, and frame_tick still pulses every 32 cycles. After that, assert reset mid-slot (digit_idx = 2) -> anodos = 1111 and buffers are blank on the next cycle.
